if_id_hazard_da: RTL and testbench

IF/ID pipeline register combined with the ID-stage hazard controller. Captures the fetched instruction and PC+4 from the fetch stage, and holds them during stalls. Inserts a bubble on a taken-branch flush. Detects load-use and branch-operand hazards, then drives pc_write back to fetch and a control bubble into ID/EX. Also keeps saturating stall/flush event counters.

---
 rtl/if_id_hazard_da.sv | 144 ++++++++++++++
 tb/tb_if_id_hazard_da.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_hazard_da.sv
// IF/ID pipeline register with the ID-stage hazard controller.
// Holds the fetched instruction and PC+4 for decode, squashes it on a taken
// branch, and stalls fetch/bubbles ID/EX on load-use and branch-operand
// hazards. Also keeps saturating stall and flush event counters.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   if_instr, if_pc4    instruction and PC+4 from fetch
//   if_flush_n          0 = taken branch, squash the IF/ID slot
//   id_ex_mem_read      EX instruction is a load
//   id_ex_reg_write     EX instruction writes a register
//   id_ex_dest          EX destination register
//   id_ex_valid         EX slot holds a real instruction
//   if_id_instr/pc4     registered instruction and PC+4 for decode
//   if_id_valid         decode slot holds a real instruction
//   pc_write            PC update enable (0 = hold PC)
//   id_ex_bubble        zero the control signals entering ID/EX
//   stall_count         saturating count of stall cycles
//   flush_count         saturating count of flush events
module if_id_hazard_da #(
    parameter logic [5:0]  BRANCH_OPCODE = 6'b000100,
    parameter logic [31:0] NOP_INSTR     = 32'h0000_0000,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc4,
    input  logic             if_flush_n,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic [4:0]       id_ex_dest,
    input  logic             id_ex_valid,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             pc_write,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        HOLD1 = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     state_next;
    logic       stall;
    logic       flush;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       gate;
    logic       is_br;
    logic       lu;
    logic       br_alu;
    logic       br_ld;

    assign flush = ~if_flush_n;
    assign op    = if_id_instr[31:26];
    assign rs    = if_id_instr[25:21];
    assign rt    = if_id_instr[20:16];

    // $0 and bubbles on either side can never create a dependency.
    assign gate  = if_id_valid & id_ex_valid & (id_ex_dest != 5'd0);
    assign is_br = (op == BRANCH_OPCODE);

    assign lu     = gate & id_ex_mem_read
                  & ((id_ex_dest == rs) | (id_ex_dest == rt));
    assign br_alu = gate & is_br & id_ex_reg_write & ~id_ex_mem_read
                  & (id_ex_dest == rs);
    // A branch on a loaded value waits until the load data is in WB,
    // hence one extra cycle held in HOLD1.
    assign br_ld  = gate & is_br & id_ex_mem_read & (id_ex_dest == rs);

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        unique case (state)
            IDLE: begin
                stall = lu | br_alu | br_ld;
                if (br_ld) begin
                    state_next = HOLD1;
                end
            end
            HOLD1: begin
                stall      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pc_write     = ~stall;
    assign id_ex_bubble = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (flush) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_instr <= if_instr;
            if_id_pc4   <= if_pc4;
            if_id_valid <= 1'b1;
        end
    end

    // A flushed cycle is not counted as a stall even if stall was high.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_ONE;
            end
            if (!flush && stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_if_id_hazard_da.sv
// Randomized and directed self-checking bench for if_id_hazard_da.
// Reference model tracks the slot contents and pending stall cycles.
module tb_if_id_hazard_da;

    localparam logic [5:0] BR_OP = 6'b000100;
    localparam int         MAXC  = 65535;

    logic        clk;
    logic        reset;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_flush_n;
    logic        id_ex_mem_read;
    logic        id_ex_reg_write;
    logic [4:0]  id_ex_dest;
    logic        id_ex_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        pc_write;
    logic        id_ex_bubble;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    if_id_hazard_da #(
        .BRANCH_OPCODE(BR_OP),
        .NOP_INSTR    (32'h0000_0000),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_instr       (if_instr),
        .if_pc4         (if_pc4),
        .if_flush_n     (if_flush_n),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_reg_write(id_ex_reg_write),
        .id_ex_dest     (id_ex_dest),
        .id_ex_valid    (id_ex_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .pc_write       (pc_write),
        .id_ex_bubble   (id_ex_bubble),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: slot contents, number of stall cycles still owed, counters.
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    int          m_owed;
    int          m_sc;
    int          m_fc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic m_depends(input logic need_br, input logic rt_too);
        logic [4:0] rs;
        logic [4:0] rt;
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        if (!m_valid || !id_ex_valid || id_ex_dest == 5'd0) return 1'b0;
        if (need_br && m_instr[31:26] != BR_OP) return 1'b0;
        return (id_ex_dest == rs) || (rt_too && id_ex_dest == rt);
    endfunction

    function automatic logic m_br_ld();
        return id_ex_mem_read && m_depends(1'b1, 1'b0);
    endfunction

    function automatic logic m_stall();
        if (m_owed > 0) return 1'b1;
        if (id_ex_mem_read && m_depends(1'b0, 1'b1)) return 1'b1;
        if (id_ex_reg_write && !id_ex_mem_read && m_depends(1'b1, 1'b0))
            return 1'b1;
        return m_br_ld();
    endfunction

    task automatic m_reset();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_owed  = 0;
        m_sc    = 0;
        m_fc    = 0;
    endtask

    // One cycle: inputs already set after a falling edge.
    task automatic cyc();
        logic s;
        logic bl;
        #1;
        s  = m_stall();
        bl = m_br_ld();
        chk("pc_write", 64'(pc_write), 64'(!s));
        chk("bubble", 64'(id_ex_bubble), 64'(s));
        chk("instr", 64'(if_id_instr), 64'(m_instr));
        chk("pc4", 64'(if_id_pc4), 64'(m_pc4));
        chk("valid", 64'(if_id_valid), 64'(m_valid));
        chk("stall_cnt", 64'(stall_count), 64'(m_sc));
        chk("flush_cnt", 64'(flush_count), 64'(m_fc));
        @(posedge clk);
        if (reset) begin
            m_reset();
        end else if (!if_flush_n) begin
            if (m_fc < MAXC) m_fc++;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_owed  = 0;
        end else if (s) begin
            if (m_sc < MAXC) m_sc++;
            if (m_owed > 0) m_owed--;
            else if (bl) m_owed = 1;
        end else begin
            m_instr = if_instr;
            m_pc4   = if_pc4;
            m_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic set_ex(input logic mr, input logic rw,
                          input logic [4:0] d, input logic v);
        id_ex_mem_read  = mr;
        id_ex_reg_write = rw;
        id_ex_dest      = d;
        id_ex_valid     = v;
    endtask

    task automatic ex_idle();
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
        return {op, rs, rt, 16'h0010};
    endfunction

    int pre;

    initial begin
        reset      = 1'b1;
        if_instr   = 32'h0;
        if_pc4     = 32'h0;
        if_flush_n = 1'b1;
        ex_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();

        // Reset values and a plain load.
        do_reset();
        chk("rst_instr", 64'(if_id_instr), 64'h0);
        chk("rst_valid", 64'(if_id_valid), 64'h0);
        chk("rst_pcw", 64'(pc_write), 64'h1);
        if_instr = 32'h2108_0001;
        if_pc4   = 32'd4;
        cyc();
        chk("t1_instr", 64'(if_id_instr), 64'h2108_0001);
        chk("t1_pc4", 64'(if_id_pc4), 64'd4);
        chk("t1_valid", 64'(if_id_valid), 64'h1);

        // Load-use on rs=3, then the same with dest=$0.
        do_reset();
        if_instr = mk(6'h08, 5'd3, 5'd1);
        if_pc4   = 32'd8;
        cyc();
        set_ex(1'b1, 1'b1, 5'd3, 1'b1);
        if_instr = 32'hAAAA_0001;
        if_pc4   = 32'd12;
        cyc();
        chk("lu_hold", 64'(if_id_instr), 64'(mk(6'h08, 5'd3, 5'd1)));
        chk("lu_cnt", 64'(stall_count), 64'd1);
        ex_idle();
        cyc();
        chk("lu_resume", 64'(if_id_instr), 64'hAAAA_0001);
        do_reset();
        if_instr = mk(6'h08, 5'd3, 5'd0);
        cyc();
        set_ex(1'b1, 1'b1, 5'd0, 1'b1);
        if_instr = 32'hBBBB_0002;
        cyc();
        chk("r0_nostall", 64'(stall_count), 64'd0);
        chk("r0_load", 64'(if_id_instr), 64'hBBBB_0002);

        // Branch after load: two stall cycles.
        do_reset();
        if_instr = mk(BR_OP, 5'd5, 5'd0);
        cyc();
        set_ex(1'b1, 1'b1, 5'd5, 1'b1);
        if_instr = 32'hCCCC_0003;
        cyc();
        ex_idle();
        chk("brld_pcw1", 64'(pc_write), 64'h0);
        cyc();
        chk("brld_cnt", 64'(stall_count), 64'd2);
        chk("brld_pcw2", 64'(pc_write), 64'h1);
        cyc();
        chk("brld_resume", 64'(if_id_instr), 64'hCCCC_0003);

        // Branch after ALU op: one stall cycle.
        do_reset();
        if_instr = mk(BR_OP, 5'd7, 5'd2);
        cyc();
        set_ex(1'b0, 1'b1, 5'd7, 1'b1);
        cyc();
        ex_idle();
        cyc();
        chk("bralu_cnt", 64'(stall_count), 64'd1);

        // Flush while in the second branch-load stall cycle.
        do_reset();
        if_instr = mk(BR_OP, 5'd5, 5'd0);
        cyc();
        set_ex(1'b1, 1'b1, 5'd5, 1'b1);
        cyc();
        ex_idle();
        if_flush_n = 1'b0;
        if_instr   = 32'hDDDD_0004;
        cyc();
        if_flush_n = 1'b1;
        chk("fl_instr", 64'(if_id_instr), 64'h0);
        chk("fl_valid", 64'(if_id_valid), 64'h0);
        chk("fl_fcnt", 64'(flush_count), 64'd1);
        chk("fl_scnt", 64'(stall_count), 64'd1);
        chk("fl_pcw", 64'(pc_write), 64'h1);
        cyc();

        // Reset during the second branch-load stall cycle.
        do_reset();
        if_instr = mk(BR_OP, 5'd6, 5'd0);
        cyc();
        set_ex(1'b1, 1'b1, 5'd6, 1'b1);
        cyc();
        ex_idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rh_pcw", 64'(pc_write), 64'h1);
        cyc();

        // Counter saturation.
        do_reset();
        if_instr = mk(6'h08, 5'd3, 5'd1);
        cyc();
        set_ex(1'b1, 1'b1, 5'd3, 1'b1);
        for (int i = 0; i < MAXC + 4; i++) cyc();
        chk("sat_cnt", 64'(stall_count), 64'hFFFF);
        ex_idle();
        do_reset();
        chk("sat_rst_s", 64'(stall_count), 64'h0);
        chk("sat_rst_f", 64'(flush_count), 64'h0);
        chk("sat_rst_v", 64'(if_id_valid), 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            pre = int'($urandom_range(0, 1));
            if_instr = {pre[0] ? BR_OP : 6'($urandom_range(0, 63)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        16'($urandom)};
            if_pc4          = $urandom;
            if_flush_n      = ($urandom_range(0, 9) != 0);
            reset           = ($urandom_range(0, 49) == 0);
            id_ex_mem_read  = 1'($urandom);
            id_ex_reg_write = 1'($urandom);
            id_ex_dest      = 5'($urandom_range(0, 7));
            id_ex_valid     = ($urandom_range(0, 3) != 0);
            cyc();
        end
        reset      = 1'b0;
        if_flush_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
